alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 64, data path width in bits; legal values are powers of two from 8 to 64.
REQ-002 Localparam: SHAMT_W = $clog2(WIDTH), shift-amount width.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operation offered.
REQ-007 in_ready  output  1  operation accepted this cycle when in_valid is also high.
REQ-008 A, B  input  WIDTH each  operands.
REQ-009 cntrl  input  3  opcode.
REQ-010 set_flags  input  1  commit this operation's flags to the flag register.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  operation result.
REQ-014 negative, zero, overflow, carry_out  output  1 each  flags of the presented result.
REQ-015 flags_q  output  4  committed {N,Z,V,C} register.

Function
REQ-016 Opcodes SHALL be: 000 result=B; 001 result=A<<B[SHAMT_W-1:0]; 010 A+B; 011 A-B; 100 A&B; 101 A|B; 110 A^B; 111 result=A>>B[SHAMT_W-1:0] (logical).
REQ-017 Subtraction SHALL be computed as A+~B+1; carry_out=1 means no borrow.
REQ-018 overflow SHALL be set on add/sub when operand signs make the signed result unrepresentable; overflow and carry_out SHALL be 0 for all other opcodes.
REQ-019 negative SHALL equal result[WIDTH-1]; zero SHALL be 1 iff result is all zeros, for every opcode.
REQ-020 The pipeline SHALL have two register stages: stage 1 captures A, B, cntrl, set_flags; stage 2 captures result and flags; latency from accepted input to out_valid is 2 cycles.
REQ-021 Input transfer occurs when in_valid&&in_ready; output transfer when out_valid&&out_ready.
REQ-022 stall = out_valid && !out_ready; in_ready SHALL equal !stall; during stall both stages hold contents unchanged.
REQ-023 With out_ready held high, the block SHALL sustain one operation per cycle.
REQ-024 result and flag outputs SHALL remain stable while out_valid is high and out_ready is low.
REQ-025 flags_q SHALL update on the output-transfer cycle of an operation with set_flags=1, taking that operation's {N,Z,V,C}; otherwise it holds.
REQ-026 An empty stage SHALL propagate as a bubble (valid=0); bubbles never change flags_q.
REQ-027 Unaccepted inputs (in_valid low or in_ready low) SHALL not enter the pipeline.

Reset
REQ-028 While reset_n is low at a rising edge, both stage valids, out_valid, result, all flag outputs and flags_q SHALL become 0.
REQ-029 in_ready SHALL be 1 during and after reset.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations without output transfer or flags_q update.

Configuration
REQ-031 Macro ALU_PIPE_SHIFT_EN: when defined, opcodes 001 and 111 perform shifts per REQ-016.
REQ-032 When ALU_PIPE_SHIFT_EN is undefined, opcodes 001 and 111 SHALL produce result 0 (zero=1, negative=0, overflow=0, carry_out=0) with no shifter logic present.

Structure
REQ-033 Package alu_pkg SHALL hold the opcode enum alu_op_e (ALU_PASS_B, ALU_LSL, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_LSR) and the flag-vector bit indices.
REQ-034 Sub-module alu_core SHALL be the purely combinational, WIDTH-parametrised evaluator of result and flags; alu_pipe holds the registers and handshake.

Verification (WIDTH=64)
REQ-035 Add: A=64'h7FFF_FFFF_FFFF_FFFF, B=1, cntrl=010, set_flags=1 -> 2 cycles later result=64'h8000_0000_0000_0000, N=1 Z=0 V=1 C=0; flags_q=4'b1010 after transfer.
REQ-036 Sub: A=5, B=5, cntrl=011, set_flags=0 -> result=0, Z=1, C=1, V=0; flags_q unchanged.
REQ-037 Back-to-back: ten ops on consecutive cycles, out_ready=1 -> ten results on consecutive cycles, in order.
REQ-038 Backpressure: out_ready low 3 cycles with pipeline full -> in_ready=0, result stable, no lost or duplicated op after release.
REQ-039 Shift: A=1, B=64'h47 (shamt 7), cntrl=001 -> result=128 with ALU_PIPE_SHIFT_EN; result=0, Z=1 without.
REQ-040 Reset mid-flight: reset_n low one cycle with two ops in flight -> out_valid=0, flags_q=0, no output transfer follows.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the alu_pipe block.
//   alu_op_e      : 3-bit opcode encoding driven on alu_pipe.cntrl
//   FLAG_*        : bit positions of N, Z, V, C inside a {N,Z,V,C} flag vector
//   add_overflow  : signed-overflow detector for a two's complement adder
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'b000,
        ALU_LSL    = 3'b001,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_XOR    = 3'b110,
        ALU_LSR    = 3'b111
    } alu_op_e;

    localparam int FLAG_W = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    // Overflow of a + b_eff: both adder inputs share a sign but the sum has
    // the opposite sign. For subtraction b_eff is the inverted B operand.
    function automatic logic add_overflow(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb
    );
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Assemble a {N,Z,V,C} vector from individual flag bits.
    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic n,
        input logic z,
        input logic v,
        input logic c
    );
        logic [FLAG_W-1:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational evaluator of one ALU operation and its flags.
//   a, b    : operands (WIDTH bits)
//   op      : opcode (alu_op_e)
//   result  : operation result (WIDTH bits)
//   flags   : {N,Z,V,C} for this result
// Configuration macro: ALU_PIPE_SHIFT_EN
//   defined   -> ALU_LSL / ALU_LSR shift A by B[SHAMT_W-1:0]
//   undefined -> both shift opcodes return zero and no shifter is built
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  alu_op_e           op,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    localparam int SHAMT_W = $clog2(WIDTH);

    logic              sub_s;
    logic              arith_s;
    logic [WIDTH-1:0]  b_eff_s;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH-1:0]  res_s;
    logic              ovf_s;
    logic              carry_s;

`ifdef ALU_PIPE_SHIFT_EN
    logic [SHAMT_W-1:0] shamt_s;
    assign shamt_s = b[SHAMT_W-1:0];
`endif

    // Shared adder: subtraction reuses it as a + ~b + 1.
    always_comb begin
        sub_s   = (op == ALU_SUB);
        arith_s = (op == ALU_ADD) || (op == ALU_SUB);
        if (sub_s) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
        sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_s};
    end

    // Result selection by opcode.
    always_comb begin
        res_s = {WIDTH{1'b0}};
        case (op)
            ALU_PASS_B: res_s = b;
`ifdef ALU_PIPE_SHIFT_EN
            ALU_LSL:    res_s = a << shamt_s;
            ALU_LSR:    res_s = a >> shamt_s;
`else
            ALU_LSL:    res_s = {WIDTH{1'b0}};
            ALU_LSR:    res_s = {WIDTH{1'b0}};
`endif
            ALU_ADD:    res_s = sum_s[WIDTH-1:0];
            ALU_SUB:    res_s = sum_s[WIDTH-1:0];
            ALU_AND:    res_s = a & b;
            ALU_OR:     res_s = a | b;
            ALU_XOR:    res_s = a ^ b;
            default:    res_s = {WIDTH{1'b0}};
        endcase
    end

    // V and C only carry meaning for add/sub; forced low elsewhere.
    always_comb begin
        ovf_s   = 1'b0;
        carry_s = 1'b0;
        if (arith_s) begin
            ovf_s   = add_overflow(a[WIDTH-1], b_eff_s[WIDTH-1], res_s[WIDTH-1]);
            carry_s = sum_s[WIDTH];
        end else begin
            ovf_s   = 1'b0;
            carry_s = 1'b0;
        end
    end

    assign result = res_s;
    assign flags  = pack_flags(res_s[WIDTH-1], (res_s == {WIDTH{1'b0}}), ovf_s, carry_s);

endmodule

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU with valid/ready handshake and a committed flag
// register.
//   clk        : rising-edge clock
//   reset_n    : synchronous active-low reset
//   in_valid   : operation offered
//   in_ready   : operation accepted this cycle when in_valid is high
//   A, B       : operands (WIDTH bits)
//   cntrl      : opcode (see alu_pkg::alu_op_e)
//   set_flags  : commit this operation's flags to flags_q on output transfer
//   out_valid  : result available
//   out_ready  : consumer accepts result
//   result     : operation result
//   negative, zero, overflow, carry_out : flags of the presented result
//   flags_q    : committed {N,Z,V,C}
// Stage 1 registers the operands and opcode, stage 2 registers the evaluated
// result and flags, giving a two-cycle latency. Whenever the output is held
// (out_valid && !out_ready) both stages freeze and in_ready drops.
// Configuration macro: ALU_PIPE_SHIFT_EN (enables the shift opcodes in
// alu_core; without it opcodes 001/111 return zero).
// -----------------------------------------------------------------------------
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    input  logic             set_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic [3:0]       flags_q
);

    // Stage 1: captured operation
    logic              s1_valid_r;
    logic [WIDTH-1:0]  s1_a_r;
    logic [WIDTH-1:0]  s1_b_r;
    alu_op_e           s1_op_r;
    logic              s1_setf_r;

    // Stage 2: evaluated operation presented on the outputs
    logic              out_valid_r;
    logic [WIDTH-1:0]  result_r;
    logic [FLAG_W-1:0] flags_r;
    logic              s2_setf_r;

    logic [FLAG_W-1:0] flags_q_r;

    // Handshake and core outputs
    logic              stall_s;
    logic              accept_s;
    logic              xfer_s;
    logic [WIDTH-1:0]  core_result_s;
    logic [FLAG_W-1:0] core_flags_s;

    assign stall_s  = out_valid_r && !out_ready;
    assign accept_s = in_valid && !stall_s;
    assign xfer_s   = out_valid_r && out_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (s1_a_r),
        .b      (s1_b_r),
        .op     (s1_op_r),
        .result (core_result_s),
        .flags  (core_flags_s)
    );

    // Stage 1 register: takes accepted inputs, otherwise loads a bubble;
    // operand data is only rewritten on acceptance to avoid needless toggling.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= ALU_PASS_B;
            s1_setf_r  <= 1'b0;
        end else if (!stall_s) begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_a_r    <= A;
                s1_b_r    <= B;
                s1_op_r   <= alu_op_e'(cntrl);
                s1_setf_r <= set_flags;
            end
        end
    end

    // Stage 2 register: captures the core output when stage 1 holds a valid op.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            flags_r     <= 4'b0000;
            s2_setf_r   <= 1'b0;
        end else if (!stall_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r  <= core_result_s;
                flags_r   <= core_flags_s;
                s2_setf_r <= s1_setf_r;
            end
        end
    end

    // Committed flag register: only a transferred op with set_flags updates it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q_r <= 4'b0000;
        end else if (xfer_s && s2_setf_r) begin
            flags_q_r <= flags_r;
        end
    end

    assign in_ready  = !stall_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign negative  = flags_r[FLAG_N];
    assign zero      = flags_r[FLAG_Z];
    assign overflow  = flags_r[FLAG_V];
    assign carry_out = flags_r[FLAG_C];
    assign flags_q   = flags_q_r;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Scoreboard bench for alu_pipe (WIDTH=64). A driver issues directed vectors
// and pushes hand-computed expected results; a monitor on the falling edge
// pops and compares whenever an output is presented, and tracks the expected
// committed flag register.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [2:0]    cntrl;
    logic          set_flags;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          negative;
    logic          zero;
    logic          overflow;
    logic          carry_out;
    logic [3:0]    flags_q;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         sf;
    } exp_t;

    exp_t        sb[$];
    logic [3:0]  model_fq = 4'b0000;
    int          n_cmp = 0;
    int          n_fail = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .set_flags (set_flags),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out),
        .flags_q   (flags_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one op, wait (bounded) for acceptance, record its expectation.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                        input logic sf, input logic [W-1:0] er, input logic [3:0] ef);
        bit ok;
        exp_t e;
        A = a; B = b; cntrl = op; set_flags = sf; in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL accept_timeout: in_ready stuck low for op %b", op);
        end else begin
            e.res = er; e.fl = ef; e.sf = sf;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: committed flags, presented result/flags, stall behaviour.
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            sb.delete();
            model_fq = 4'b0000;
        end else begin
            chk("flags_q", 64'(flags_q), 64'(model_fq));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    n_cmp  = n_cmp + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_output: result %h with empty scoreboard", result);
                end else begin
                    e = sb[0];
                    chk("result", result, e.res);
                    chk("flags", 64'({negative, zero, overflow, carry_out}), 64'(e.fl));
                    if (!out_ready) begin
                        chk("in_ready_stall", 64'(in_ready), 64'd0);
                    end else begin
                        if (e.sf) model_fq = e.fl;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; cntrl = 3'b000; set_flags = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_flags", 64'({negative, zero, overflow, carry_out}), 64'd0);
        chk("rst_flags_q", 64'(flags_q), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Directed vectors: {N,Z,V,C}
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b1, 64'h8000_0000_0000_0000, 4'b1010);
        send(64'd5, 64'd5, 3'b011, 1'b0, 64'd0, 4'b0101);
        send(64'd0, 64'hFFFF_0000_0000_0000, 3'b000, 1'b0, 64'hFFFF_0000_0000_0000, 4'b1000);
        send(64'h00FF, 64'h0F0F, 3'b100, 1'b0, 64'h000F, 4'b0000);
        send(64'h8000_0000_0000_0000, 64'd1, 3'b101, 1'b0, 64'h8000_0000_0000_0001, 4'b1000);
        send(64'h1234, 64'h1234, 3'b110, 1'b1, 64'd0, 4'b0100);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, 1'b0, 64'd0, 4'b0101);
        send(64'd3, 64'd5, 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        send(64'h8000_0000_0000_0000, 64'd1, 3'b011, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
`ifdef ALU_PIPE_SHIFT_EN
        send(64'd1, 64'h47, 3'b001, 1'b0, 64'd128, 4'b0000);
        send(64'h8000_0000_0000_0000, 64'd63, 3'b111, 1'b0, 64'd1, 4'b0000);
`else
        send(64'd1, 64'h47, 3'b001, 1'b0, 64'd0, 4'b0100);
        send(64'h8000_0000_0000_0000, 64'd63, 3'b111, 1'b0, 64'd0, 4'b0100);
`endif

        // Back-to-back: ten adds on consecutive cycles.
        for (int i = 0; i < 10; i++) begin
            send(64'(i), 64'd100, 3'b010, 1'b0, 64'(i + 100), 4'b0000);
        end
        repeat (4) @(posedge clk); #1;

        // Backpressure: fill the pipe with out_ready low, hold 3 stall cycles.
        out_ready = 1'b0;
        send(64'd10, 64'd20, 3'b010, 1'b0, 64'd30, 4'b0000);
        send(64'd100, 64'd1, 3'b011, 1'b1, 64'd99, 4'b0001);
        fork
            send(64'h00F0, 64'h000F, 3'b101, 1'b0, 64'h00FF, 4'b0000);
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk); #1;

        // Reset with two ops in flight: both must vanish, flags_q clears.
        send(64'd0, 64'h8000_0000_0000_0000, 3'b000, 1'b1, 64'h8000_0000_0000_0000, 4'b1000);
        send(64'd0, 64'hF000_0000_0000_0000, 3'b000, 1'b1, 64'hF000_0000_0000_0000, 4'b1000);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_flags_q", 64'(flags_q), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (4) @(posedge clk); #1;

        // Pipeline still works after reset.
        send(64'd7, 64'd9, 3'b110, 1'b1, 64'd14, 4'b0000);

        for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
        repeat (3) @(posedge clk);
        chk("drain", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
